// File: rtl/cache_axi_bridge.sv
// Bridges ICache/DCache line refills and DCache writebacks onto one AXI4 master port.
// Independent read and write FSMs; a DCache read waits on a pending writeback to the same line.
//
//   state  | meaning
//   R_IDLE | arbitrate DCache (priority) / ICache refill requests
//   R_AR   | AR channel valid, waiting for arready
//   R_DATA | forwarding R beats to the owning cache until rlast
//   W_IDLE | waiting for a writeback request
//   W_AW   | AW channel valid, waiting for awready
//   W_DATA | streaming the buffered line on W, one word per wready
//   W_RESP | waiting for the B response
module cache_axi_bridge #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int OFFS_W     = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_rreq,
  input  logic [ADDR_W-1:0]       i_raddr,
  output logic                    i_rgnt,
  output logic                    i_rvalid,
  output logic                    i_rlast,
  input  logic                    d_rreq,
  input  logic [ADDR_W-1:0]       d_raddr,
  output logic                    d_rgnt,
  output logic                    d_rvalid,
  output logic                    d_rlast,
  output logic [31:0]             rdata_o,
  input  logic                    d_wreq,
  input  logic [ADDR_W-1:0]       d_waddr,
  input  logic [32*LINE_WORDS-1:0] d_wline,
  output logic                    d_wgnt,
  output logic                    d_wdone,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [3:0]              arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [31:0]             rdata,
  input  logic [3:0]              rid,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [7:0]              awlen,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0] BLEN = 8'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFS_W) - ADDR_W'(1));

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

  rstate_t rstate, rnext;
  wstate_t wstate, wnext;

  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [ADDR_W-1:0] d_rline, i_rline, d_wline_addr;
  logic              rown_d;
  logic              wpend;
  logic [31:0]       wbuf [LINE_WORDS];
  logic [CNT_W-1:0]  wcnt;
  logic              d_sel, i_sel, w_take, blocked, rbeat;
  logic              rid_unused;

  assign rid_unused   = ^rid;
  assign d_rline      = d_raddr & LINE_MASK;
  assign i_rline      = i_raddr & LINE_MASK;
  assign d_wline_addr = d_waddr & LINE_MASK;

  // Also block a same-line read racing a writeback that is being accepted this cycle.
  assign blocked = (wpend && (d_rline == waddr_q)) ||
                   ((wstate == W_IDLE) && d_wreq && (d_rline == d_wline_addr));

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rstate <= R_IDLE;
    else       rstate <= rnext;
  end

  always_comb begin
    rnext = rstate;
    d_sel = 1'b0;
    i_sel = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (d_rreq && !blocked) begin
          d_sel = 1'b1;
          rnext = R_AR;
        end else if (i_rreq) begin
          i_sel = 1'b1;
          rnext = R_AR;
        end
      end
      R_AR:    if (arready) rnext = R_DATA;
      R_DATA:  if (rvalid && rlast) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raddr_q <= '0;
      rown_d  <= 1'b0;
      d_rgnt  <= 1'b0;
      i_rgnt  <= 1'b0;
    end else begin
      d_rgnt <= d_sel;
      i_rgnt <= i_sel;
      if (d_sel) begin
        raddr_q <= d_rline;
        rown_d  <= 1'b1;
      end else if (i_sel) begin
        raddr_q <= i_rline;
        rown_d  <= 1'b0;
      end
    end
  end

  assign arvalid  = (rstate == R_AR);
  assign araddr   = raddr_q;
  assign arlen    = arvalid ? BLEN : 8'd0;
  assign arid     = arvalid ? {3'b000, rown_d} : 4'd0;
  assign rready   = (rstate == R_DATA);
  assign rbeat    = rready && rvalid;
  assign d_rvalid = rbeat && rown_d;
  assign i_rvalid = rbeat && !rown_d;
  assign d_rlast  = d_rvalid && rlast;
  assign i_rlast  = i_rvalid && rlast;
  assign rdata_o  = rbeat ? rdata : 32'd0;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wstate <= W_IDLE;
    else       wstate <= wnext;
  end

  always_comb begin
    wnext  = wstate;
    w_take = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (d_wreq) begin
          w_take = 1'b1;
          wnext  = W_AW;
        end
      end
      W_AW:    if (awready) wnext = W_DATA;
      W_DATA:  if (wready && (wcnt == LAST_IDX)) wnext = W_RESP;
      W_RESP:  if (bvalid) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr_q <= '0;
      wpend   <= 1'b0;
      d_wgnt  <= 1'b0;
      wcnt    <= '0;
      for (int i = 0; i < LINE_WORDS; i++) wbuf[i] <= 32'd0;
    end else begin
      d_wgnt <= w_take;
      if (w_take) begin
        waddr_q <= d_wline_addr;
        wpend   <= 1'b1;
        for (int i = 0; i < LINE_WORDS; i++) wbuf[i] <= d_wline[32*i +: 32];
      end
      if (wstate == W_AW)
        wcnt <= '0;
      else if ((wstate == W_DATA) && wready)
        wcnt <= wcnt + CNT_W'(1);
      if ((wstate == W_RESP) && bvalid)
        wpend <= 1'b0;
    end
  end

  assign awvalid = (wstate == W_AW);
  assign awaddr  = waddr_q;
  assign awlen   = awvalid ? BLEN : 8'd0;
  assign wvalid  = (wstate == W_DATA);
  assign wdata   = wvalid ? wbuf[wcnt] : 32'd0;
  assign wlast   = wvalid && (wcnt == LAST_IDX);
  assign bready  = (wstate == W_RESP);
  assign d_wdone = bready && bvalid;

endmodule
